// File: rtl/haar_address_sequencer_pkg.sv
// Shared definitions for the Haar feature-memory address sequencer and its control FSM.
package haar_address_sequencer_pkg;

  // Sequencer state encoding, also used by the classifier control FSM.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } seq_state_e;

  // Walk modes latched at start.
  localparam logic ModeOneshot = 1'b0;
  localparam logic ModeWrap    = 1'b1;

endpackage

// File: rtl/haar_address_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module haar_address_sequencer_sat_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/haar_address_sequencer.sv
// Walks the feature/stage memory from a latched base with a latched stride and run length,
// advancing only on the compare-stage handshake. One-shot or wrap-around.
module haar_address_sequencer
  import haar_address_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STRIDE_WIDTH = 4,
  parameter int unsigned WRAP_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic                    i_mode,
  input  logic [ADDR_WIDTH-1:0]   i_base_address,
  input  logic [STRIDE_WIDTH-1:0] i_stride,
  input  logic [DATA_WIDTH-1:0]   i_max_size,
  input  logic                    trigger_compare,
  output logic [ADDR_WIDTH-1:0]   o_address,
  output logic [DATA_WIDTH-1:0]   o_count,
  output logic                    o_valid,
  output logic                    o_is_end_reached,
  output logic                    o_done,
  output logic                    o_busy,
  output logic [WRAP_WIDTH-1:0]   o_wrap_count
);

  seq_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [STRIDE_WIDTH-1:0] stride_q, stride_d;
  logic [DATA_WIDTH-1:0]   size_q, size_d;
  logic                    mode_q, mode_d;
  logic                    wrap_clr, wrap_inc;
  logic                    last;

  // Last index of the pass; size_q is never zero while in StRun.
  assign last = (count_q == (size_q - DATA_WIDTH'(1)));

  // Next-state, address accumulator and index counter.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    base_d   = base_q;
    stride_d = stride_q;
    size_d   = size_q;
    mode_d   = mode_q;
    wrap_clr = 1'b0;
    wrap_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          base_d   = i_base_address;
          stride_d = i_stride;
          size_d   = i_max_size;
          mode_d   = i_mode;
          wrap_clr = 1'b1;
          count_d  = '0;
          if (i_max_size != '0) begin
            state_d = StRun;
            addr_d  = i_base_address;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (i_abort) begin
          state_d = StIdle;
        end else if (trigger_compare) begin
          if (!last) begin
            count_d = count_q + DATA_WIDTH'(1);
            addr_d  = addr_q + ADDR_WIDTH'(stride_q);
          end else if (mode_q == ModeOneshot) begin
            state_d = StDone;
          end else begin
            count_d  = '0;
            addr_d   = base_q;
            wrap_inc = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      count_q  <= '0;
      base_q   <= '0;
      stride_q <= '0;
      size_q   <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      size_q   <= size_d;
      mode_q   <= mode_d;
    end
  end

  haar_address_sequencer_sat_counter #(
    .WIDTH(WRAP_WIDTH)
  ) u_wrap_counter (
    .clk   (clk),
    .reset (reset),
    .clear (wrap_clr),
    .inc   (wrap_inc),
    .count (o_wrap_count)
  );

  assign o_address        = addr_q;
  assign o_count          = count_q;
  assign o_valid          = (state_q == StRun);
  assign o_done           = (state_q == StDone);
  assign o_busy           = (state_q != StIdle);
  assign o_is_end_reached = o_valid && last;

endmodule
